tms_sequencer: RTL and testbench
================================

TMS_SEQUENCER -- requirements
Module: tms_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, maximum shift length in bits.
REQ-002 SHALL have parameter LW, default 4, width of cmd_len (2**LW >= W).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge; same clock drives the downstream TAP controller.
REQ-004 SHALL have port TRST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_op  input  2  0=RESET, 1=IDLE, 2=SHIFT_DR, 3=SHIFT_IR.
REQ-008 SHALL have port cmd_len  input  LW  bit count minus one (IDLE: cycle count minus one).
REQ-009 SHALL have port cmd_data  input  W  TDI payload, LSB shifted first.
REQ-010 SHALL have port TMS  output  1  registered TMS to TAP controller.
REQ-011 SHALL have port TDI  output  1  registered TDI.
REQ-012 SHALL have port tdo_in  input  1  TDO from target.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle pulse, command complete.
REQ-014 SHALL have port rsp_data  output  W  captured TDO bits, valid with rsp_valid.

Function
REQ-015 Command SHALL be accepted at a rising edge where cmd_valid=1 and cmd_ready=1; op, len, data latched at that edge.
REQ-016 cmd_ready SHALL be 1 only in state IDLE_WAIT; it SHALL drop the cycle after acceptance.
REQ-017 First TMS value of a command SHALL appear in the cycle immediately after acceptance; one TMS value per cycle thereafter.
REQ-018 RESET SHALL drive TMS = 1,1,1,1,1,0 (6 cycles); TAP ends in Run_Test_Idle.
REQ-019 IDLE SHALL drive TMS=0 for cmd_len+1 cycles.
REQ-020 SHIFT_DR SHALL drive header TMS = 1,0,0; SHIFT_IR header TMS = 1,1,0,0.
REQ-021 Shift phase SHALL last cmd_len+1 cycles; TMS=0 on all but the last, TMS=1 on the last; TDI in shift cycle i = cmd_data[i].
REQ-022 Trailer SHALL drive TMS = 1 then 0; TAP ends in Run_Test_Idle.
REQ-023 TDI SHALL be 0 outside shift cycles.
REQ-024 tdo_in SHALL be sampled at the edge ending shift cycle i into rsp_data[i]; bits above cmd_len SHALL be 0.
REQ-025 cmd_len >= W for shift ops SHALL be clamped to W-1.
REQ-026 rsp_valid SHALL pulse for exactly one cycle, the cycle after the last TMS cycle; cmd_ready SHALL return to 1 the cycle after rsp_valid.
REQ-027 rsp_data SHALL hold its value until the next rsp_valid; it SHALL be all-zero for RESET and IDLE.
REQ-028 States: IDLE_WAIT, RST_SEQ, RTI_SEQ, HEADER, SHIFT, TRAILER, RESP; RESP -> IDLE_WAIT unconditionally.
REQ-029 cmd_valid during a busy command SHALL be ignored; no queueing.
REQ-030 Sequencer SHALL NOT track TAP state; shift ops presume the TAP starts in Run_Test_Idle.

Reset
REQ-031 TRST=1 at a rising edge SHALL force state IDLE_WAIT, TMS=1, TDI=0, rsp_valid=0, rsp_data=0, cmd_ready=0; cmd_ready SHALL be 1 the first cycle after TRST deasserts.
REQ-032 TRST mid-command SHALL abort it with no rsp_valid; TRST SHALL override a simultaneous cmd_valid.
REQ-033 TMS SHALL remain 1 while TRST=1 so the TAP is held toward Test_logic_Reset.

Verification
REQ-034 TRST 2 cycles, then RESET op -> TMS 1,1,1,1,1,0, rsp_valid 1 cycle later, rsp_data=0.
REQ-035 SHIFT_DR len=7 data=0xA5, tdo_in loopback of TDI delayed one cycle -> TMS 1,0,0,0x7,1,1,0, TDI LSB-first 1,0,1,0,0,1,0,1, rsp_data=0x00A5 with model delay accounted.
REQ-036 SHIFT_IR len=3 data=0x6, tdo_in=1 -> header 1,1,0,0, 4 shift cycles, rsp_data=0x000F.
REQ-037 IDLE len=0 -> single TMS=0 cycle, total 2 cycles from acceptance to rsp_valid.
REQ-038 TRST asserted during SHIFT cycle 3 -> no rsp_valid, TMS=1, cmd_ready=1 the cycle after release.
REQ-039 cmd_valid held high throughout a SHIFT_DR -> second command accepted only after cmd_ready returns; back-to-back outputs match REQ-017..026.

Source files
------------

// File: rtl/tms_sequencer.sv
// tms_sequencer
//
// Turns high-level JTAG commands (TAP reset, idle, DR scan, IR scan) into a
// cycle-by-cycle TMS/TDI stream for a TAP controller clocked by the same clk,
// and collects the TDO bits returned during the shift phase.
//
// Ports
//   clk          sole clock, rising edge (also clocks the downstream TAP)
//   TRST         synchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    sequencer can accept a command (registered)
//   cmd_op       0=RESET, 1=IDLE, 2=SHIFT_DR, 3=SHIFT_IR
//   cmd_len      bit count minus one (IDLE: cycle count minus one)
//   cmd_data     TDI payload, LSB shifted first
//   TMS, TDI     registered outputs to the TAP
//   tdo_in       TDO from the target
//   rsp_valid    one-cycle pulse when a command completes
//   rsp_data     captured TDO bits, held until the next rsp_valid
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: a command transfers at a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid may stay high while the sequencer is busy;
// it is simply ignored until cmd_ready returns. There is no queueing.
//
// Every output is a register, and the state register always describes the
// cycle currently being driven: the first TMS value of a command is loaded
// at the accepting edge, so it appears in the very next cycle.

module tms_sequencer #(
    parameter int W  = 16,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          TRST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [LW-1:0] cmd_len,
    input  logic [W-1:0]  cmd_data,
    output logic          TMS,
    output logic          TDI,
    input  logic          tdo_in,
    output logic          rsp_valid,
    output logic [W-1:0]  rsp_data,
    output logic [2:0]    dbg_state_o
);

    // The counter must reach 5 for the reset pattern and cmd_len for IDLE.
    localparam int CW = (LW > 3) ? LW : 3;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IDLE  = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IR    = 2'd3;

    typedef enum logic [2:0] {
        IDLE_WAIT = 3'd0,
        RST_SEQ   = 3'd1,
        RTI_SEQ   = 3'd2,
        HEADER    = 3'd3,
        SHIFT     = 3'd4,
        TRAILER   = 3'd5,
        RESP      = 3'd6
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    op_q;
    logic [LW-1:0] len_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  cap_q;
    logic          tms_q;
    logic          tdi_q;
    logic          ready_q;
    logic          rsp_valid_q;
    logic [W-1:0]  rsp_data_q;

    logic [LW-1:0] shift_len_d;
    logic [CW-1:0] cnt_inc_d;
    logic [CW-1:0] len_ext_d;
    logic [CW-1:0] hdr_last_d;

    // Shift lengths beyond the payload width are clamped to W-1.
    always_comb begin
        shift_len_d = cmd_len;
        if (int'(cmd_len) >= W) begin
            shift_len_d = LW'(W - 1);
        end
    end

    assign cnt_inc_d  = cnt_q + CW'(1);
    assign len_ext_d  = CW'(len_q);
    // DR header is 1,0,0 (3 cycles); IR header is 1,1,0,0 (4 cycles).
    assign hdr_last_d = (op_q == OP_IR) ? CW'(3) : CW'(2);

    always_ff @(posedge clk) begin
        if (TRST) begin
            state_q     <= IDLE_WAIT;
            cnt_q       <= '0;
            op_q        <= OP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            tms_q       <= 1'b1;  // hold the TAP toward Test-Logic-Reset
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE_WAIT: begin
                    if (cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        cap_q   <= '0;
                        cnt_q   <= '0;
                        case (cmd_op)
                            OP_RESET: begin
                                state_q <= RST_SEQ;
                                len_q   <= cmd_len;
                                tms_q   <= 1'b1;
                            end
                            OP_IDLE: begin
                                state_q <= RTI_SEQ;
                                len_q   <= cmd_len;
                                tms_q   <= 1'b0;
                            end
                            default: begin
                                state_q <= HEADER;
                                len_q   <= shift_len_d;
                                tms_q   <= 1'b1;
                            end
                        endcase
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                // TMS 1,1,1,1,1,0 over counter values 0..5.
                RST_SEQ: begin
                    if (cnt_q == CW'(5)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        tms_q <= (cnt_q != CW'(4));
                    end
                end

                RTI_SEQ: begin
                    if (cnt_q == len_ext_d) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        tms_q <= 1'b0;
                    end
                end

                HEADER: begin
                    if (cnt_q == hdr_last_d) begin
                        // First shift cycle: TMS=1 already if it is also the last.
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        tms_q   <= (len_q == '0);
                        tdi_q   <= data_q[0];
                        data_q  <= data_q >> 1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        tms_q <= (op_q == OP_IR) && (cnt_q == '0);
                    end
                end

                // cnt_q is the bit index of the shift cycle being driven.
                SHIFT: begin
                    cap_q <= cap_q | (W'(tdo_in) << cnt_q);
                    if (cnt_q == len_ext_d) begin
                        state_q <= TRAILER;
                        cnt_q   <= '0;
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_inc_d;
                        tms_q  <= (cnt_inc_d == len_ext_d);
                        tdi_q  <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end

                // Trailer TMS 1,0 walks Exit1 -> Update -> Run-Test/Idle.
                TRAILER: begin
                    if (cnt_q == '0) begin
                        cnt_q <= CW'(1);
                        tms_q <= 1'b0;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cap_q;
                    end
                end

                RESP: begin
                    state_q     <= IDLE_WAIT;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end

                default: begin
                    state_q     <= IDLE_WAIT;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign TMS         = tms_q;
    assign TDI         = tdi_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tms_sequencer.sv
// Directed bench for tms_sequencer. Built with W=12 so that the length
// clamp (cmd_len 15 -> 11) can be exercised with the default LW=4.

module tb_tms_sequencer;

    localparam int W  = 12;
    localparam int LW = 4;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IDLE  = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IR    = 2'd3;

    logic          clk = 1'b0;
    logic          TRST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [W-1:0]  cmd_data;
    logic          TMS;
    logic          TDI;
    logic          tdo_in;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic [2:0]    dbg_state;

    // Target model: 0 = constant, 1 = TDI looped straight back,
    // 2 = TDI looped back through one register stage.
    int   tdo_mode  = 0;
    logic tdo_const = 1'b0;
    logic tdo_dly   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Expected per-cycle {TMS, TDI} after acceptance.
    logic [1:0] exp_q[$];

    tms_sequencer #(.W(W), .LW(LW)) dut (
        .clk        (clk),
        .TRST       (TRST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .TMS        (TMS),
        .TDI        (TDI),
        .tdo_in     (tdo_in),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) tdo_dly <= TDI;

    assign tdo_in = (tdo_mode == 1) ? TDI : (tdo_mode == 2) ? tdo_dly : tdo_const;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- expected-trace model ----------------
    task automatic build_exp(input logic [1:0] op, input logic [LW-1:0] len, input logic [W-1:0] data);
        int eff;
        exp_q.delete();
        case (op)
            OP_RESET: begin
                for (int i = 0; i < 5; i++) exp_q.push_back(2'b10);
                exp_q.push_back(2'b00);
            end
            OP_IDLE: begin
                for (int i = 0; i <= int'(len); i++) exp_q.push_back(2'b00);
            end
            default: begin
                eff = (int'(len) >= W) ? W - 1 : int'(len);
                exp_q.push_back(2'b10);
                if (op == OP_IR) exp_q.push_back(2'b10);
                exp_q.push_back(2'b00);
                exp_q.push_back(2'b00);
                for (int i = 0; i <= eff; i++) exp_q.push_back({(i == eff), data[i]});
                exp_q.push_back(2'b10);
                exp_q.push_back(2'b00);
            end
        endcase
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge of the cycle in
    // which cmd_ready has come back after the response.
    task automatic run_cmd(input logic [1:0] op, input logic [LW-1:0] len, input logic [W-1:0] data,
                           input logic [W-1:0] exp_rsp, input bit hold);
        int         waitc;
        int         n;
        logic [1:0] e;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        build_exp(op, len, data);
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_ready", {31'b0, cmd_ready}, 32'd1);
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("tms[%0d]", k), {31'b0, TMS}, {31'b0, e[1]});
            check($sformatf("tdi[%0d]", k), {31'b0, TDI}, {31'b0, e[0]});
            check($sformatf("busy_rsp_valid[%0d]", k), {31'b0, rsp_valid}, 32'd0);
            check($sformatf("busy_ready[%0d]", k), {31'b0, cmd_ready}, 32'd0);
        end
        @(negedge clk);
        check("rsp_valid_pulse", {31'b0, rsp_valid}, 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
        check("rsp_ready_low", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("ready_return", {31'b0, cmd_ready}, 32'd1);
        check("rsp_data_hold", 32'(rsp_data), 32'(exp_rsp));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        TRST      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tms", {31'b0, TMS}, 32'd1);
        check("rst_tdi", {31'b0, TDI}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        TRST = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        // TAP reset: TMS 1,1,1,1,1,0, empty response.
        run_cmd(OP_RESET, 4'd0, 12'h000, 12'h000, 1'b0);

        // DR scan of 0xA5, TDI looped straight back -> payload returned intact.
        tdo_mode = 1;
        run_cmd(OP_DR, 4'd7, 12'h0A5, 12'h0A5, 1'b0);

        // Same scan through a one-cycle loopback: bit i returns data[i-1],
        // bit 0 sees the header's TDI=0, so 0xA5 becomes 0x4A.
        tdo_mode = 2;
        run_cmd(OP_DR, 4'd7, 12'h0A5, 12'h04A, 1'b0);

        // IR scan of 4 bits with TDO stuck at 1.
        tdo_mode  = 0;
        tdo_const = 1'b1;
        run_cmd(OP_IR, 4'd3, 12'h006, 12'h00F, 1'b0);
        tdo_const = 1'b0;

        // Idle for one and for three cycles.
        run_cmd(OP_IDLE, 4'd0, 12'hFFF, 12'h000, 1'b0);
        run_cmd(OP_IDLE, 4'd2, 12'h123, 12'h000, 1'b0);

        // Length 15 clamps to 11: twelve shift cycles, full payload back.
        tdo_mode = 1;
        run_cmd(OP_DR, 4'd15, 12'hABC, 12'hABC, 1'b0);

        // cmd_valid held throughout: the repeat is accepted only once ready returns.
        run_cmd(OP_DR, 4'd3, 12'h009, 12'h009, 1'b1);
        run_cmd(OP_DR, 4'd3, 12'h009, 12'h009, 1'b0);

        // Abort in shift cycle 3, with a new command offered at the same edge.
        cmd_op    = OP_DR;
        cmd_len   = 4'd7;
        cmd_data  = 12'h0FF;
        cmd_valid = 1'b1;
        check("abort_accept_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        repeat (7) @(negedge clk);
        check("abort_in_shift", 32'(dbg_state), 32'd4);
        check("abort_shift_tms", {31'b0, TMS}, 32'd0);
        TRST    = 1'b1;
        cmd_op  = OP_IDLE;
        cmd_len = 4'd0;
        @(negedge clk);
        check("abort_tms", {31'b0, TMS}, 32'd1);
        check("abort_tdi", {31'b0, TDI}, 32'd0);
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_ready", {31'b0, cmd_ready}, 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        TRST      = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_release_ready", {31'b0, cmd_ready}, 32'd1);
        check("abort_release_rsp", {31'b0, rsp_valid}, 32'd0);
        check("abort_release_tms", {31'b0, TMS}, 32'd1);

        // Normal operation resumes after the abort.
        run_cmd(OP_IDLE, 4'd1, 12'h000, 12'h000, 1'b0);
        tdo_mode = 1;
        run_cmd(OP_IR, 4'd4, 12'h015, 12'h015, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
